// File: rtl/jesd_pkg.sv
// jesd_pkg
// Shared definitions for the 8b/10b lane TX path:
//   K28_5_RDN / K28_5_RDP : the two running-disparity forms of K28.5
//   state_t               : comma-insert FSM states (IDLE, CGS, RELEASE)
//   comma_pair()          : 20-bit comma pair (two symbols) for a given
//                           starting running disparity, symbol [9:0] first
package jesd_pkg;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CGS     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // The first symbol must match the current disparity; the second one
    // uses the flipped disparity, so a pair leaves disparity unchanged.
    function automatic logic [19:0] comma_pair(input logic rd);
        logic [19:0] pair;
        if (rd) begin
            pair = {K28_5_RDN, K28_5_RDP};
        end else begin
            pair = {K28_5_RDP, K28_5_RDN};
        end
        return pair;
    endfunction

endpackage

// File: rtl/comma_insert.sv
// comma_insert
// Sits between the 8b/10b encoder and the serializer on a 20-bit lane.
// While REQ is high it replaces lane data with K28.5 comma pairs of the
// correct disparity and stalls the encoder (READY=0). After at least MIN_K
// comma cycles and once REQ drops, it returns to data aligned to an
// F_CYC-cycle frame and pulses DONE.
//
// Parameters: MIN_K (min comma cycles per session), F_CYC (frame length).
// Ports:
//   CLK, RST         lane clock, synchronous active-high reset
//   REQ              level sync request
//   DI/DVI/RD        encoded symbol pair, valid, encoder disparity
//   READY            DI accepted when DVI & READY (combinational)
//   DO/DVO/K/DONE    registered lane output, valid, comma flag, done pulse
//   CGS_CNT          completed-session count (only with COMMA_INSERT_STAT_EN)
// Build option: define COMMA_INSERT_STAT_EN to add CGS_CNT.
module comma_insert
    import jesd_pkg::*;
#(
    parameter int MIN_K = 16,
    parameter int F_CYC = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic [19:0] DI,
    input  logic        DVI,
    input  logic        RD,
    output logic        READY,
    output logic [19:0] DO,
    output logic        DVO,
    output logic        K,
    output logic        DONE
`ifdef COMMA_INSERT_STAT_EN
    ,
    output logic [15:0] CGS_CNT
`endif
);

    localparam int KW = $clog2(MIN_K + 1);
    localparam int FW = (F_CYC > 1) ? $clog2(F_CYC) : 1;
    localparam logic [KW-1:0] KMAX  = KW'(MIN_K);
    localparam logic [FW-1:0] FLAST = FW'(F_CYC - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [KW-1:0]   r_kcnt;
    logic [KW-1:0]   w_kcnt_next;
    logic [KW-1:0]   w_kcnt_inc;
    logic [FW-1:0]   r_frame;
    logic [19:0]     r_do;
    logic [19:0]     w_do_next;
    logic            r_dvo;
    logic            w_dvo_next;
    logic            r_k;
    logic            w_k_next;
    logic            r_done_pend;
    logic            w_done_pend_next;
    logic            r_done;
    logic [19:0]     w_pair;
    logic            w_kcnt_ok;

    assign w_pair     = comma_pair(RD);
    assign w_kcnt_inc = (r_kcnt == KMAX) ? r_kcnt : r_kcnt + 1'b1;
    // Counts this edge's pair as well, so the check is kcnt+1 >= MIN_K.
    assign w_kcnt_ok  = (int'(r_kcnt) + 1) >= MIN_K;

    assign READY = (r_state == IDLE) && !REQ;
    assign DO    = r_do;
    assign DVO   = r_dvo;
    assign K     = r_k;
    assign DONE  = r_done;

    always_comb begin
        w_state_next     = r_state;
        w_kcnt_next      = r_kcnt;
        w_do_next        = DI;
        w_dvo_next       = DVI;
        w_k_next         = 1'b0;
        w_done_pend_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (REQ) begin
                    w_do_next    = w_pair;
                    w_dvo_next   = 1'b1;
                    w_k_next     = 1'b1;
                    w_kcnt_next  = KW'(1);
                    w_state_next = CGS;
                end
            end
            CGS: begin
                w_do_next   = w_pair;
                w_dvo_next  = 1'b1;
                w_k_next    = 1'b1;
                w_kcnt_next = w_kcnt_inc;
                if (!REQ && w_kcnt_ok) begin
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                w_do_next   = w_pair;
                w_dvo_next  = 1'b1;
                w_k_next    = 1'b1;
                w_kcnt_next = w_kcnt_inc;
                if (REQ) begin
                    w_state_next = CGS;
                end else if (r_frame == FLAST) begin
                    // Final pair goes out now; DONE lands with the first
                    // IDLE output cycle, one edge later.
                    w_state_next     = IDLE;
                    w_done_pend_next = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_kcnt      <= '0;
            r_frame     <= '0;
            r_do        <= '0;
            r_dvo       <= 1'b0;
            r_k         <= 1'b0;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_kcnt      <= w_kcnt_next;
            r_frame     <= (r_frame == FLAST) ? '0 : r_frame + 1'b1;
            r_do        <= w_do_next;
            r_dvo       <= w_dvo_next;
            r_k         <= w_k_next;
            r_done_pend <= w_done_pend_next;
            r_done      <= r_done_pend;
        end
    end

`ifdef COMMA_INSERT_STAT_EN
    logic [15:0] r_cgs_cnt;

    // Increments on the same edge that raises DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cgs_cnt <= '0;
        end else if (r_done_pend && (r_cgs_cnt != 16'hFFFF)) begin
            r_cgs_cnt <= r_cgs_cnt + 16'd1;
        end
    end

    assign CGS_CNT = r_cgs_cnt;
`endif

endmodule

// File: tb/tb_comma_insert.sv
// tb_comma_insert
// Table-driven check of comma_insert (MIN_K=4, F_CYC=4) plus a hand-written
// sequence on a second instance with MIN_K=1, F_CYC=1.
module tb_comma_insert;

    localparam logic [19:0] P0 = 20'b1100000101_0011111010; // RD=0 pair
    localparam logic [19:0] P1 = 20'b0011111010_1100000101; // RD=1 pair

    logic        clk;
    logic        rst;
    logic        req;
    logic [19:0] di;
    logic        dvi;
    logic        rd;
    logic        ready,  ready2;
    logic [19:0] dout,   dout2;
    logic        dvo,    dvo2;
    logic        k,      k2;
    logic        done,   done2;
`ifdef COMMA_INSERT_STAT_EN
    logic [15:0] cgs_cnt, cgs_cnt2;
`endif

    comma_insert #(.MIN_K(4), .F_CYC(4)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .DI(di), .DVI(dvi), .RD(rd),
        .READY(ready), .DO(dout), .DVO(dvo), .K(k), .DONE(done)
`ifdef COMMA_INSERT_STAT_EN
        , .CGS_CNT(cgs_cnt)
`endif
    );

    comma_insert #(.MIN_K(1), .F_CYC(1)) dut2 (
        .CLK(clk), .RST(rst), .REQ(req), .DI(di), .DVI(dvi), .RD(rd),
        .READY(ready2), .DO(dout2), .DVO(dvo2), .K(k2), .DONE(done2)
`ifdef COMMA_INSERT_STAT_EN
        , .CGS_CNT(cgs_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, req, rd, dvi;
        logic [19:0] di;
        logic        ck_rdy, e_rdy;
        logic [19:0] e_do;
        logic        e_dvo, e_k, e_done;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void add(logic r, logic q, logic d, logic v, logic [19:0] x,
                                logic ck, logic rdy, logic [19:0] eo,
                                logic ev, logic ek, logic ed);
        vec_t t;
        t.rst = r; t.req = q; t.rd = d; t.dvi = v; t.di = x;
        t.ck_rdy = ck; t.e_rdy = rdy; t.e_do = eo;
        t.e_dvo = ev; t.e_k = ek; t.e_done = ed;
        tbl.push_back(t);
    endfunction

    // Reset row: random data, all outputs zero after the edge.
    function automatic void add_rst(logic ck, logic rdy);
        add(1'b1, 1'b0, 1'b0, 1'($urandom), 20'($urandom), ck, rdy, 20'h0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        int exp_cnt;
        exp_cnt = 0;
        rst = 1'b1; req = 1'b0; di = '0; dvi = 1'b0; rd = 1'b0;

        // Power-on reset, 3 cycles
        add_rst(1'b0, 1'b0); add_rst(1'b1, 1'b1); add_rst(1'b1, 1'b1);
        // A: pass-through, then RD=0 session with REQ high for 2 cycles
        add(0,0,0,1,20'hABCDE, 1,1, 20'hABCDE,1,0,0);
        add(0,1,0,1,20'h12345, 1,0, P0,1,1,0);   // REQ sampled, first pair
        add(0,1,0,1,20'h12345, 1,0, P0,1,1,0);
        add(0,0,0,1,20'h12345, 1,0, P0,1,1,0);
        add(0,0,0,1,20'h12345, 1,0, P0,1,1,0);   // kcnt reaches 4 -> RELEASE
        add(0,0,0,1,20'h12345, 1,0, P0,1,1,0);
        add(0,0,0,1,20'h12345, 1,0, P0,1,1,0);
        add(0,0,0,1,20'h12345, 1,0, P0,1,1,0);   // frame_cnt=3: final pair
        add(0,0,0,1,20'h12345, 1,1, 20'h12345,1,0,1); // frame-aligned data, DONE
        add(0,0,0,0,20'h00000, 1,1, 20'h00000,0,0,0);
        // B: RD=1 session, REQ re-asserted in RELEASE
        add_rst(1'b1, 1'b1); add_rst(1'b1, 1'b1); add_rst(1'b1, 1'b1);
        add(0,1,1,1,20'h0AAAA, 1,0, P1,1,1,0);
        add(0,0,1,1,20'h0AAAA, 1,0, P1,1,1,0);
        add(0,0,1,1,20'h0AAAA, 1,0, P1,1,1,0);
        add(0,0,1,1,20'h0AAAA, 1,0, P1,1,1,0);   // -> RELEASE
        add(0,1,1,1,20'h0AAAA, 1,0, P1,1,1,0);   // REQ again -> CGS, no DONE
        add(0,0,1,1,20'h0AAAA, 1,0, P1,1,1,0);   // -> RELEASE
        add(0,0,1,1,20'h0AAAA, 1,0, P1,1,1,0);
        add(0,0,1,1,20'h0AAAA, 1,0, P1,1,1,0);   // final pair
        add(0,0,1,1,20'h0AAAA, 1,1, 20'h0AAAA,1,0,1);
        add(0,0,1,1,20'h0BBBB, 1,1, 20'h0BBBB,1,0,0);
        // C: reset in the middle of CGS, then a normal session
        add_rst(1'b1, 1'b1); add_rst(1'b1, 1'b1); add_rst(1'b1, 1'b1);
        add(0,1,0,1,20'h0D0D0, 1,0, P0,1,1,0);
        add(0,1,0,1,20'h0D0D0, 1,0, P0,1,1,0);
        add_rst(1'b1, 1'b0);                      // RST while in CGS
        add(0,1,0,1,20'h0D0D0, 1,0, P0,1,1,0);   // kcnt restarts at 1
        add(0,0,0,1,20'h0D0D0, 1,0, P0,1,1,0);
        add(0,0,0,1,20'h0D0D0, 1,0, P0,1,1,0);
        add(0,0,0,1,20'h0D0D0, 1,0, P0,1,1,0);   // -> RELEASE at frame_cnt=3
        add(0,0,0,1,20'h0D0D0, 1,0, P0,1,1,0);
        add(0,0,0,1,20'h0D0D0, 1,0, P0,1,1,0);
        add(0,0,0,1,20'h0D0D0, 1,0, P0,1,1,0);
        add(0,0,0,1,20'h0D0D0, 1,0, P0,1,1,0);   // final pair
        add(0,0,0,1,20'h0D0D0, 1,1, 20'h0D0D0,1,0,1);
        add(0,0,0,0,20'h0EEEE, 1,1, 20'h0EEEE,0,0,0);

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; rd = tbl[i].rd;
            dvi = tbl[i].dvi; di = tbl[i].di;
            #1;
            if (tbl[i].ck_rdy) chk($sformatf("v%0d READY", i), 20'(ready), 20'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d DO", i),   dout,       tbl[i].e_do);
            chk($sformatf("v%0d DVO", i),  20'(dvo),   20'(tbl[i].e_dvo));
            chk($sformatf("v%0d K", i),    20'(k),     20'(tbl[i].e_k));
            chk($sformatf("v%0d DONE", i), 20'(done),  20'(tbl[i].e_done));
            if (tbl[i].rst) exp_cnt = 0;
            else if (tbl[i].e_done) exp_cnt++;
`ifdef COMMA_INSERT_STAT_EN
            chk($sformatf("v%0d CGS_CNT", i), 20'(cgs_cnt), 20'(exp_cnt));
`endif
            $display("vec %0d rst=%0b req=%0b rd=%0b di=%h -> rdy=%0b do=%h dvo=%0b k=%0b done=%0b",
                     i, tbl[i].rst, tbl[i].req, tbl[i].rd, tbl[i].di, ready, dout, dvo, k, done);
        end

        // MIN_K=1, F_CYC=1: leave after the first pair, no frame wait.
        rst = 1'b1; req = 1'b0; dvi = 1'b0; di = '0; rd = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b1;
        @(posedge clk); #1;
        chk("m1 entry DO", dout2, P0);
        chk("m1 entry K", 20'(k2), 20'd1);
        req = 1'b0;
        #1; chk("m1 READY in CGS", 20'(ready2), 20'd0);
        @(posedge clk); #1;
        chk("m1 cgs K", 20'(k2), 20'd1);
        chk("m1 cgs DONE", 20'(done2), 20'd0);
        @(posedge clk); #1;
        chk("m1 final K", 20'(k2), 20'd1);
        chk("m1 final DONE", 20'(done2), 20'd0);
        di = 20'h0CCCC; dvi = 1'b1;
        #1; chk("m1 READY idle", 20'(ready2), 20'd1);
        @(posedge clk); #1;
        chk("m1 data DO", dout2, 20'h0CCCC);
        chk("m1 data K", 20'(k2), 20'd0);
        chk("m1 data DONE", 20'(done2), 20'd1);
        @(posedge clk); #1;
        chk("m1 DONE one cycle", 20'(done2), 20'd0);
        $display("seq m1 done2 sequence complete, do=%h", dout2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/comma_insert.md
# comma_insert

TX-side counterpart of the link receiver's comma detector: it sits between the 8b/10b encoder and the serializer on a 20-bit (two-symbol) lane. While the link partner requests code-group synchronisation, it replaces lane data with a continuous stream of K28.5 comma pairs of correct running disparity. It then returns to data on a frame boundary and stalls the encoder for the whole comma period, so encoder disparity stays continuous.

## Interface
- MIN_K, 16: minimum number of comma cycles emitted per sync session (≥1).
- F_CYC, 4: frame length in lane cycles; return to data is aligned to this (≥1).
- CLK  in  1  lane clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  1  level sync request (high = emit commas).
- DI  in  20  two encoded symbols; DI[9:0] is transmitted first.
- DVI  in  1  DI valid.
- RD  in  1  encoder running disparity before DI[9:0] (0 = RD−, 1 = RD+).
- READY  out  1  DI accepted this cycle when DVI & READY.
- DO  out  20  lane output, DO[9:0] first.
- DVO  out  1  DO valid.
- K  out  1  DO carries a comma pair.
- DONE  out  1  one-cycle pulse on return to data.

## Operation
- K28.5 codes: RD− 10'b0011111010, RD+ 10'b1100000101. Comma pair for RD=0: DO[9:0]=RD− code, DO[19:10]=RD+ code. For RD=1 the order is swapped. Each pair leaves disparity unchanged.
- READY = (state==IDLE) & ~REQ, combinational. The encoder does not advance while READY=0, so RD is stable throughout CGS.
- frame_cnt: free-running 0..F_CYC−1, wraps, cleared by RST.
- kcnt: comma cycles emitted this session, saturating at MIN_K.
- States:
  - IDLE: DO←DI, DVO←DVI, K←0 each edge. If REQ=1: DO←pair, DVO←1, K←1, kcnt←1, go to CGS.
  - CGS: DO←pair, DVO←1, K←1, kcnt++ (saturating). If ~REQ & kcnt≥MIN_K−1, go to RELEASE (this edge's pair is counted).
  - RELEASE: emit pairs as in CGS. REQ=1 → back to CGS, kcnt kept. Else if frame_cnt==F_CYC−1: emit final pair, go to IDLE, DONE←1 next edge.
- Consequence: the first post-CGS data word appears on DO in the cycle after frame_cnt wrapped to 0, i.e. frame-aligned.
- REQ rising mid-data stream: the word presented in that cycle is not accepted (READY=0) and is held by the upstream side.

## Timing
- Reset values: DO=0, DVO=0, K=0, DONE=0, state IDLE, kcnt=0, frame_cnt=0. READY follows state and REQ immediately after reset.
- Data latency: 1 cycle, DI→DO.
- REQ→first comma on DO: 1 cycle (same edge that samples REQ).
- DONE: high exactly one cycle, coincident with the first IDLE-state output cycle (DVO may be 0 then).
- RST during CGS/RELEASE: next cycle IDLE with outputs as at reset, no DONE.
- MIN_K=1: exit allowed right after the first pair, still waits for frame alignment.
- F_CYC=1: exit immediately once the kcnt condition holds.

## Configuration
- COMMA_INSERT_STAT_EN defined: adds output CGS_CNT [15:0], the count of completed sessions (increments on DONE), saturating at 16'hFFFF, reset 0.
- Not defined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package jesd_pkg holds:
  - K28_5_RDN and K28_5_RDP constants.
  - the state enum (IDLE, CGS, RELEASE).
  - a function returning the 20-bit comma pair given RD.
- Single flat module, no sub-module: the logic is one FSM, two counters and an output register.

## Test plan
- Reset: assert RST 3 cycles with random DI/DVI → DO=0, DVO=0, K=0, DONE=0; CGS_CNT=0 if enabled.
- Pass-through: REQ=0, DVI=1, DI=20'hABCDE → DO=20'hABCDE, DVO=1, K=0 one cycle later; READY=1 throughout.
- Session, MIN_K=4, F_CYC=4, RD=0, REQ high 2 cycles:
  - DO=20'b1100000101_0011111010 with K=1 for at least 4 cycles.
  - Return to data only after frame_cnt=3.
  - DONE pulses once, first data word on DO is frame-aligned.
  - READY=0 for the whole session.
- RD=1 session → DO=20'b0011111010_1100000101 on every comma cycle.
- REQ re-asserted in RELEASE → back to CGS with no DONE; DONE appears only after the final release.
- RST mid-CGS → IDLE next cycle, K=0, no DONE. A following session behaves normally with kcnt restarting at 1.
